// File: rtl/modport_top_if.sv
// Byte-stream handshake bundle between a stream source and the UART transmitter.
interface modport_top_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] axis_data;
    logic                  axis_valid;
    logic                  axis_last;
    logic                  m_axis_ready;

    modport master (
        output axis_data,
        output axis_valid,
        output axis_last,
        input  m_axis_ready
    );

    modport slave (
        input  axis_data,
        input  axis_valid,
        input  axis_last,
        output m_axis_ready
    );
endinterface

// File: rtl/modport_top.sv
// Stream-to-UART transmitter: FIFO-buffered 8N1 serializer with an on-chip loopback receiver.
module modport_top #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  rst,
    modport_top_if.slave          axis,
    output logic                  uart_tx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ClkW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW = $clog2(DATA_WIDTH);

    localparam logic [CntW-1:0] CountFull = CntW'(FIFO_DEPTH);
    localparam logic [PtrW-1:0] PtrLast   = PtrW'(FIFO_DEPTH - 1);
    localparam logic [ClkW-1:0] ClkLast   = ClkW'(CLKS_PER_BIT - 1);
    localparam logic [ClkW-1:0] HalfLast  = ClkW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BitW-1:0] TxBitLast = BitW'(DATA_WIDTH - 1);
    localparam logic [BitW-1:0] RxBitLast = BitW'(DATA_WIDTH - 2);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    // FIFO
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  ready, push, pop;

    // TX
    tx_state_e             tx_state_q, tx_state_d;
    logic [ClkW-1:0]       tx_cnt_q, tx_cnt_d;
    logic [BitW-1:0]       tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_line_q, tx_line_d;

    // RX
    rx_state_e             rx_state_q, rx_state_d;
    logic [ClkW-1:0]       rx_cnt_q, rx_cnt_d;
    logic [BitW-1:0]       rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_meta_q, rx_sync_q;

    // End-of-packet marker is accepted but carries no meaning on the serial line.
    logic unused_last;
    assign unused_last = axis.axis_last;

    assign ready             = (count_q != CountFull);
    assign axis.m_axis_ready = ready;
    assign push              = axis.axis_valid && ready;
    assign uart_tx           = tx_line_q;
    assign rx_data           = rx_data_q;
    assign rx_valid          = rx_valid_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        pop        = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                tx_line_d = 1'b1;
                if (count_q != '0) begin
                    pop        = 1'b1;
                    tx_shift_d = mem_q[rd_ptr_q];
                    tx_line_d  = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == ClkLast) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TxData: begin
                if (tx_cnt_q == ClkLast) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == TxBitLast) begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TxStop;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TxStop: begin
                if (tx_cnt_q == ClkLast) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit so queued frames are gapless.
                    if (count_q != '0) begin
                        pop        = 1'b1;
                        tx_shift_d = mem_q[rd_ptr_q];
                        tx_line_d  = 1'b0;
                        tx_state_d = TxStart;
                    end else begin
                        tx_line_d  = 1'b1;
                        tx_state_d = TxIdle;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                // A high level during the half-bit qualification window is a glitch.
                if (rx_sync_q) begin
                    rx_cnt_d = '0;
                end else if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxStart;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStart: begin
                if (rx_cnt_q == ClkLast) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_WIDTH-1:1]};
                    rx_state_d = RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == ClkLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_WIDTH-1:1]};
                    if (rx_bit_q == RxBitLast) rx_state_d = RxStop;
                    else                       rx_bit_d   = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == ClkLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    if (rx_sync_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= axis.axis_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            rx_meta_q  <= tx_line_q;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end
endmodule

// File: tb/tb_modport_top.sv
// Bench for modport_top: frame-level reference model checked every cycle, plus directed literals.
module tb_modport_top;
    localparam int unsigned CPB   = 16;
    localparam int          FRAME = 10 * CPB;
    // Receiver reports at the stop-bit centre, seen through a 2-flop synchronizer.
    localparam int          RX_LAT = 9 * CPB + CPB / 2 + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_tx;
    logic [7:0] rx_data;
    logic       rx_valid;

    always #5 clk = ~clk;

    modport_top_if #(.DATA_WIDTH(8)) axis_bus ();

    modport_top #(
        .DATA_WIDTH  (8),
        .FIFO_DEPTH  (8),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .axis    (axis_bus),
        .uart_tx (uart_tx),
        .rx_data (rx_data),
        .rx_valid(rx_valid)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    logic [7:0] m_fifo[$];
    logic [7:0] exp_b[$];
    int         exp_t[$];
    bit         m_active = 0;
    int         m_start  = 0;
    logic [7:0] m_cur    = 8'h00;
    logic       m_ready  = 1'b1;
    logic       m_tx     = 1'b1;
    logic       m_rxv    = 1'b0;
    logic [7:0] m_rxd    = 8'h00;
    bit         m_acc    = 0;
    int         acc_cyc  = 0;

    logic [7:0] rx_log[$];
    int         rx_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a byte leaves the queue when the line is free or the current frame ends.
    initial forever begin
        bit pre_ready;
        int idx;
        @(posedge clk);
        cyc++;
        m_acc = 0;
        if (!rst) begin
            m_fifo.delete();
            exp_t.delete();
            exp_b.delete();
            m_active = 0;
            m_rxd    = 8'h00;
            m_rxv    = 1'b0;
        end else begin
            pre_ready = (m_fifo.size() != 8);
            if (m_active && cyc == m_start + FRAME) m_active = 0;
            m_rxv = 1'b0;
            if (exp_t.size() > 0 && exp_t[0] == cyc) begin
                m_rxv = 1'b1;
                m_rxd = exp_b[0];
                void'(exp_t.pop_front());
                void'(exp_b.pop_front());
            end
            if (!m_active && m_fifo.size() > 0) begin
                m_cur    = m_fifo.pop_front();
                m_start  = cyc;
                m_active = 1;
                exp_t.push_back(cyc + RX_LAT);
                exp_b.push_back(m_cur);
            end
            if (axis_bus.axis_valid && pre_ready) begin
                m_fifo.push_back(axis_bus.axis_data);
                m_acc   = 1;
                acc_cyc = cyc;
            end
        end
        m_ready = (m_fifo.size() != 8);
        m_tx    = 1'b1;
        if (m_active) begin
            idx = (cyc - m_start) / CPB;
            if (idx == 0)      m_tx = 1'b0;
            else if (idx <= 8) m_tx = m_cur[idx-1];
        end
    end

    // Per-cycle comparison and receive log
    initial forever begin
        @(negedge clk);
        chk("uart_tx", {31'd0, uart_tx}, {31'd0, m_tx});
        chk("ready", {31'd0, axis_bus.m_axis_ready}, {31'd0, m_ready});
        chk("rx_valid", {31'd0, rx_valid}, {31'd0, m_rxv});
        chk("rx_data", {24'd0, rx_data}, {24'd0, m_rxd});
        if (rx_valid === 1'b1) begin
            rx_log.push_back(rx_data);
            rx_cyc.push_back(cyc);
        end
    end

    task automatic send_byte(input logic [7:0] data, input logic last, output int t_acc);
        int budget;
        axis_bus.axis_data  = data;
        axis_bus.axis_last  = last;
        axis_bus.axis_valid = 1'b1;
        budget = 20 * FRAME;
        t_acc  = -1;
        while (budget > 0) begin
            @(negedge clk);
            budget--;
            if (m_acc) begin
                t_acc = acc_cyc;
                break;
            end
        end
        if (t_acc < 0) chk("accept_timeout", 32'd0, 32'd1);
        axis_bus.axis_valid = 1'b0;
        axis_bus.axis_last  = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int deadline);
        while (rx_log.size() < n && cyc < deadline) @(negedge clk);
        chk("rx_count", rx_log.size(), n);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_frame(input string name, input int t_acc, input logic [9:0] pat);
        for (int k = 0; k < 10; k++) begin
            wait_until(t_acc + 1 + k * CPB + CPB / 2);
            chk(name, {31'd0, uart_tx}, {31'd0, pat[k]});
        end
    endtask

    initial begin
        int t0, t1, tn;
        axis_bus.axis_data  = 8'h00;
        axis_bus.axis_valid = 1'b0;
        axis_bus.axis_last  = 1'b0;

        // 1: reset values
        repeat (5) @(negedge clk);
        chk("rst_ready", {31'd0, axis_bus.m_axis_ready}, 32'd1);
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_tx", {31'd0, uart_tx}, 32'd1);
        chk("idle_ready", {31'd0, axis_bus.m_axis_ready}, 32'd1);

        // 2: single byte 0xA5
        rx_log.delete(); rx_cyc.delete();
        send_byte(8'hA5, 1'b0, t0);
        check_frame("frame_a5", t0, 10'b1101001010);
        wait_rx(1, t0 + 11 * CPB);
        if (rx_log.size() >= 1) begin
            chk("rx_a5", {24'd0, rx_log[0]}, 32'hA5);
            chk("lat_a5", rx_cyc[0] - t0, 32'd155);
        end
        repeat (CPB) @(negedge clk);

        // 3: burst until full, then one more after the next pop
        rx_log.delete(); rx_cyc.delete();
        send_byte(8'h01, 1'b0, t1);
        for (int b = 2; b <= 9; b++) send_byte(8'(b), 1'b0, tn);
        chk("full_ready", {31'd0, axis_bus.m_axis_ready}, 32'd0);
        send_byte(8'h0A, 1'b0, tn);
        chk("refill_time", tn - t1, 32'd162);
        wait_rx(10, t1 + 11 * FRAME);
        for (int i = 0; i < rx_log.size(); i++) begin
            chk("burst_data", {24'd0, rx_log[i]}, i + 1);
            if (i > 0) chk("burst_gap", rx_cyc[i] - rx_cyc[i-1], FRAME);
        end
        repeat (CPB) @(negedge clk);

        // 4: boundary bytes back to back
        rx_log.delete(); rx_cyc.delete();
        send_byte(8'h00, 1'b0, t0);
        send_byte(8'hFF, 1'b0, tn);
        wait_rx(2, t0 + 3 * FRAME);
        repeat (FRAME) @(negedge clk);
        chk("bound_count", rx_log.size(), 32'd2);
        if (rx_log.size() >= 2) begin
            chk("bound_00", {24'd0, rx_log[0]}, 32'h00);
            chk("bound_ff", {24'd0, rx_log[1]}, 32'hFF);
        end

        // 5: reset during the data bits with two bytes queued
        rx_log.delete(); rx_cyc.delete();
        send_byte(8'h3C, 1'b0, t0);
        send_byte(8'h77, 1'b0, tn);
        send_byte(8'h88, 1'b0, tn);
        wait_until(t0 + 1 + 3 * CPB);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_tx", {31'd0, uart_tx}, 32'd1);
        chk("abort_ready", {31'd0, axis_bus.m_axis_ready}, 32'd1);
        repeat (3 * FRAME) @(negedge clk);
        chk("abort_no_rx", rx_log.size(), 32'd0);
        send_byte(8'h5A, 1'b0, t0);
        wait_rx(1, t0 + 11 * CPB);
        if (rx_log.size() >= 1) chk("rx_5a", {24'd0, rx_log[0]}, 32'h5A);
        repeat (CPB) @(negedge clk);

        // 6: axis_last has no effect on the frame
        rx_log.delete(); rx_cyc.delete();
        send_byte(8'h11, 1'b1, t0);
        check_frame("frame_11", t0, 10'b1000100010);
        wait_rx(1, t0 + 11 * CPB);
        if (rx_log.size() >= 1) begin
            chk("rx_11", {24'd0, rx_log[0]}, 32'h11);
            chk("lat_11", rx_cyc[0] - t0, 32'd155);
        end
        repeat (2 * CPB) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
